// File: rtl/bp_be_dual_retire_queue_pkg.sv
// Shared types for the dual retire queue: exception/special flag structs and
// the retire entry payload that travels from writeback to the system pipe.
package bp_be_dual_retire_queue_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int unsigned dpath_width_gp = 64;

  typedef struct packed {
    logic instr_misaligned;
    logic instr_access_fault;
    logic illegal_instr;
    logic breakpoint;
    logic load_misaligned;
    logic load_access_fault;
    logic store_misaligned;
    logic store_access_fault;
    logic ecall;
  } bp_be_exception_s;

  typedef struct packed {
    logic fencei;
    logic sfence_vma;
    logic mret;
    logic sret;
    logic dret;
    logic wfi;
  } bp_be_special_s;

  typedef struct packed {
    logic                      queue_v;
    logic [dpath_width_gp-1:0] data;
    bp_be_exception_s          exception;
    bp_be_special_s            special;
  } bp_be_retire_entry_s;

  localparam int unsigned exception_width_gp = $bits(bp_be_exception_s);
  localparam int unsigned special_width_gp   = $bits(bp_be_special_s);
  localparam int unsigned entry_width_gp     = $bits(bp_be_retire_entry_s);

endpackage

// File: rtl/bp_be_dual_retire_queue_fifo_2w2r.sv
// Circular buffer with two write ports and two read ports.
//   clk_i, reset_i    : clock, async active-high reset (empties the buffer)
//   clr_i             : synchronous clear, beats any push/pop in the same cycle
//   push_n_i          : number of entries written (0..2); wdata0 goes first
//   pop_n_i           : number of entries removed from the head (0..2)
//   rdata0/1_o        : entries at rptr and rptr+1 (combinational)
//   count_o           : occupied entries, 0..els_p
module bp_be_fifo_2w2r
 #(parameter int unsigned els_p   = 8,
   parameter int unsigned width_p = 8,
   localparam int unsigned ptr_width_lp = $clog2(els_p),
   localparam int unsigned cnt_width_lp = ptr_width_lp + 1)
  (input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clr_i,
   input  logic [1:0]              push_n_i,
   input  logic [width_p-1:0]      wdata0_i,
   input  logic [width_p-1:0]      wdata1_i,
   input  logic [1:0]              pop_n_i,
   output logic [width_p-1:0]      rdata0_o,
   output logic [width_p-1:0]      rdata1_o,
   output logic [cnt_width_lp-1:0] count_o);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rptr_r, wptr_r;
  logic [ptr_width_lp-1:0] rptr_p1, wptr_p1;
  logic [cnt_width_lp-1:0] count_r;

  // Power-of-two depth lets pointer arithmetic wrap for free.
  assign rptr_p1 = rptr_r + ptr_width_lp'(1);
  assign wptr_p1 = wptr_r + ptr_width_lp'(1);

  // Pointers and occupancy; count is tracked explicitly so full and empty differ.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else if (clr_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      rptr_r  <= rptr_r + ptr_width_lp'(pop_n_i);
      wptr_r  <= wptr_r + ptr_width_lp'(push_n_i);
      count_r <= count_r + cnt_width_lp'(push_n_i) - cnt_width_lp'(pop_n_i);
    end
  end

  // Storage has no reset; contents are meaningless outside the occupied window.
  always_ff @(posedge clk_i) begin
    if (!clr_i && (push_n_i != 2'd0)) mem_r[wptr_r]  <= wdata0_i;
    if (!clr_i && (push_n_i == 2'd2)) mem_r[wptr_p1] <= wdata1_i;
  end

  assign rdata0_o = mem_r[rptr_r];
  assign rdata1_o = mem_r[rptr_p1];
  assign count_o  = count_r;

endmodule

// File: rtl/bp_be_dual_retire_queue.sv
// In-order retire buffer feeding the system pipe's two retire slots.
//   clk_i, reset_i       : clock, async active-high reset
//   flush_i              : discard everything; blocks enqueue and retire this cycle
//   enq_v_i/enq_entry_i  : older incoming entry
//   enq_v_i2/enq_entry_i2: younger incoming entry
//   enq_ready_o          : at least two free slots (pre-dequeue count)
//   retire_ready_i       : system pipe accepts retirement this cycle
//   retire_*_o / *_o2    : slot 1 (oldest) and slot 2 head view and valids
//   count_o              : occupied entries
module bp_be_dual_retire_queue
  import bp_be_dual_retire_queue_pkg::*;
 #(parameter bp_params_e  bp_params_p = e_bp_default_cfg,
   parameter int unsigned els_p       = 8,
   localparam int unsigned ptr_width_lp   = $clog2(els_p),
   localparam int unsigned entry_width_lp = $bits(bp_be_retire_entry_s))
  (input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          flush_i,
   input  logic                          enq_v_i,
   input  logic [entry_width_lp-1:0]     enq_entry_i,
   input  logic                          enq_v_i2,
   input  logic [entry_width_lp-1:0]     enq_entry_i2,
   output logic                          enq_ready_o,
   input  logic                          retire_ready_i,
   output logic                          retire_v_o,
   output logic                          retire_v_o2,
   output logic                          retire_queue_v_o,
   output logic                          retire_queue_v_o2,
   output logic [dpath_width_gp-1:0]     retire_data_o,
   output logic [dpath_width_gp-1:0]     retire_data_o2,
   output logic [exception_width_gp-1:0] retire_exception_o,
   output logic [exception_width_gp-1:0] retire_exception_o2,
   output logic [special_width_gp-1:0]   retire_special_o,
   output logic [special_width_gp-1:0]   retire_special_o2,
   output logic [ptr_width_lp:0]         count_o);

  localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

  bp_be_retire_entry_s     slot1, slot2;
  logic [entry_width_lp-1:0] head0, head1, wdata0;
  logic [1:0]              push_n, pop_n;
  logic                    enq_ok, drain, clr;
  logic [cnt_width_lp-1:0] count;

  // Enqueue is credited only from the current count; pops this cycle do not help.
  assign enq_ready_o = (count <= cnt_width_lp'(els_p - 2));
  assign enq_ok      = enq_ready_o & ~flush_i;

  // A lone younger entry is packed into the first write port to keep order dense.
  assign wdata0 = enq_v_i ? enq_entry_i : enq_entry_i2;
  assign push_n = enq_ok ? (2'(enq_v_i) + 2'(enq_v_i2)) : 2'd0;

  assign slot1 = head0;
  assign slot2 = head1;

  // Slot 2 may not retire behind a slot 1 that traps or serializes.
  assign retire_v_o  = retire_ready_i & ~flush_i & (count != '0);
  assign retire_v_o2 = retire_v_o & (count >= cnt_width_lp'(2))
                     & ~|slot1.exception & ~|slot1.special;
  assign pop_n       = 2'(retire_v_o) + 2'(retire_v_o2);

  // Any retiring exception squashes all younger work, including this cycle's enqueue.
  assign drain = (retire_v_o & |slot1.exception) | (retire_v_o2 & |slot2.exception);
  assign clr   = flush_i | drain;

  bp_be_fifo_2w2r #(
    .els_p   (els_p),
    .width_p (entry_width_lp)
  ) fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (clr),
    .push_n_i (push_n),
    .wdata0_i (wdata0),
    .wdata1_i (enq_entry_i2),
    .pop_n_i  (pop_n),
    .rdata0_o (head0),
    .rdata1_o (head1),
    .count_o  (count)
  );

  assign count_o             = count;
  assign retire_queue_v_o    = slot1.queue_v;
  assign retire_queue_v_o2   = slot2.queue_v;
  assign retire_data_o       = slot1.data;
  assign retire_data_o2      = slot2.data;
  assign retire_exception_o  = slot1.exception;
  assign retire_exception_o2 = slot2.exception;
  assign retire_special_o    = slot1.special;
  assign retire_special_o2   = slot2.special;

`ifndef SYNTHESIS
  // Enqueue without credit is a producer bug; the entries are dropped.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i) begin
      assert (!((enq_v_i | enq_v_i2) & ~enq_ready_o))
        else $error("enqueue while enq_ready_o is low");
    end
    assert ((els_p >= 4) && ((els_p & (els_p - 1)) == 0) && (bp_params_p == e_bp_default_cfg))
      else $error("unsupported queue configuration");
  end
`endif

endmodule
